// File: rtl/usb2_endp_router.sv
// usb2_endp_router
// Steers the USB 2.0 packet-layer buffer interface to one of NUM_EP endpoint
// buffers and returns that endpoint's status through registers. Also keeps
// the per-endpoint DATA0/DATA1 toggle and halt (STALL) state.
//
// Ports
//   phy_clk, reset          clock, async active-high reset
//   sel_endp                endpoint chosen by the packet layer
//   buf_in_* / buf_out_*    packet-side write and read paths (strobes in,
//                           registered status of the selected endpoint out)
//   data_toggle_act         advance the selected endpoint's toggle
//   toggle_clr_all          clear every toggle
//   halt_set/halt_clr/halt_ep  set or clear the halt of endpoint halt_ep
//   ep_*                    flattened per-endpoint buffer signals, EP n at [n*w +: w]
//   endp_mode, data_toggle, endp_valid, endp_halted  selected-endpoint info
//   fsm_state               selection FSM state, for observation
//
// Handshake: a strobe (wren/commit/arm/toggle act) is a one-cycle request that
// is forwarded only in ST_ACTIVE, when sel_endp still equals the latched
// selection, the endpoint exists and is not halted. A strobe presented in any
// other cycle is dropped, never held or replayed.
module usb2_endp_router #(
  parameter int                  NUM_EP   = 4,
  parameter int                  ADDR_W   = 9,
  parameter int                  LEN_W    = 10,
  parameter logic [2*NUM_EP-1:0] EP_MODES = 8'b10_10_10_00
) (
  input  logic                      phy_clk,
  input  logic                      reset,
  input  logic [3:0]                sel_endp,
  input  logic [ADDR_W-1:0]         buf_in_addr,
  input  logic [7:0]                buf_in_data,
  input  logic                      buf_in_wren,
  input  logic                      buf_in_commit,
  input  logic [LEN_W-1:0]          buf_in_commit_len,
  output logic                      buf_in_ready,
  output logic                      buf_in_commit_ack,
  input  logic [ADDR_W-1:0]         buf_out_addr,
  input  logic                      buf_out_arm,
  output logic [7:0]                buf_out_q,
  output logic [LEN_W-1:0]          buf_out_len,
  output logic                      buf_out_hasdata,
  output logic                      buf_out_arm_ack,
  input  logic                      data_toggle_act,
  input  logic                      toggle_clr_all,
  input  logic                      halt_set,
  input  logic                      halt_clr,
  input  logic [3:0]                halt_ep,
  output logic [NUM_EP*ADDR_W-1:0]  ep_buf_in_addr,
  output logic [NUM_EP*8-1:0]       ep_buf_in_data,
  output logic [NUM_EP-1:0]         ep_buf_in_wren,
  output logic [NUM_EP-1:0]         ep_buf_in_commit,
  output logic [NUM_EP*LEN_W-1:0]   ep_buf_in_commit_len,
  input  logic [NUM_EP-1:0]         ep_buf_in_ready,
  input  logic [NUM_EP-1:0]         ep_buf_in_commit_ack,
  output logic [NUM_EP*ADDR_W-1:0]  ep_buf_out_addr,
  output logic [NUM_EP-1:0]         ep_buf_out_arm,
  input  logic [NUM_EP*8-1:0]       ep_buf_out_q,
  input  logic [NUM_EP*LEN_W-1:0]   ep_buf_out_len,
  input  logic [NUM_EP-1:0]         ep_buf_out_hasdata,
  input  logic [NUM_EP-1:0]         ep_buf_out_arm_ack,
  output logic [1:0]                endp_mode,
  output logic [1:0]                data_toggle,
  output logic                      endp_valid,
  output logic                      endp_halted,
  output logic [1:0]                fsm_state
);

  localparam logic [4:0] NUM_EP_L = 5'(NUM_EP);
  localparam logic [1:0] MODE_ISO = 2'b01;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        sel_q, sel_nxt;
  logic [NUM_EP-1:0] toggles, tog_nxt;
  logic [NUM_EP-1:0] halts, halt_nxt;

  // EP0 is always a control endpoint whatever the mode table says.
  function automatic logic [1:0] ep_mode(input int n);
    if (n == 0) return 2'b00;
    return EP_MODES[2*n +: 2];
  endfunction

  // Selection FSM: every change of sel_endp costs one guard cycle in ST_SETTLE.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state <= ST_RST;
      sel_q <= 4'd0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    case (state)
      ST_RST:    state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        sel_nxt   = sel_endp;
        state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: if (sel_endp != sel_q) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_RST;
    endcase
  end

  assign fsm_state = state;

  // Selected-endpoint view. An out-of-range sel_q matches no endpoint, so all
  // of these stay 0 for it.
  logic             valid;
  logic             sel_halt, sel_tog, sel_ready, sel_cack, sel_hasdata, sel_aack;
  logic [1:0]       sel_mode;
  logic [7:0]       sel_rq;
  logic [LEN_W-1:0] sel_len;

  assign valid = (state != ST_RST) && ({1'b0, sel_q} < NUM_EP_L);

  always_comb begin
    sel_halt    = 1'b0;
    sel_tog     = 1'b0;
    sel_mode    = 2'b00;
    sel_ready   = 1'b0;
    sel_cack    = 1'b0;
    sel_rq      = '0;
    sel_len     = '0;
    sel_hasdata = 1'b0;
    sel_aack    = 1'b0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (sel_q == 4'(n)) begin
        sel_halt    = halts[n];
        sel_tog     = toggles[n];
        sel_mode    = ep_mode(n);
        sel_ready   = ep_buf_in_ready[n];
        sel_cack    = ep_buf_in_commit_ack[n];
        sel_rq      = ep_buf_out_q[n*8 +: 8];
        sel_len     = ep_buf_out_len[n*LEN_W +: LEN_W];
        sel_hasdata = ep_buf_out_hasdata[n];
        sel_aack    = ep_buf_out_arm_ack[n];
      end
    end
  end

  logic pass, ret_en, ep0_setup;

  // The sel_endp == sel_q term drops a strobe arriving in the same cycle as a
  // selection change, before the FSM has even left ST_ACTIVE.
  assign pass      = (state == ST_ACTIVE) && (sel_endp == sel_q) && valid && !sel_halt;
  assign ret_en    = (state == ST_ACTIVE) && valid && !sel_halt;
  // EP0 commit seen even while halted: a new SETUP clears the control STALL.
  assign ep0_setup = (state == ST_ACTIVE) && (sel_endp == sel_q) && (sel_q == 4'd0) &&
                     buf_in_commit;

  // Forward path to the endpoints.
  always_comb begin
    ep_buf_in_addr       = '0;
    ep_buf_in_data       = '0;
    ep_buf_in_wren       = '0;
    ep_buf_in_commit     = '0;
    ep_buf_in_commit_len = '0;
    ep_buf_out_addr      = '0;
    ep_buf_out_arm       = '0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (valid && sel_q == 4'(n)) begin
        ep_buf_in_addr[n*ADDR_W +: ADDR_W]     = buf_in_addr;
        ep_buf_in_data[n*8 +: 8]               = buf_in_data;
        ep_buf_in_commit_len[n*LEN_W +: LEN_W] = buf_in_commit_len;
        ep_buf_out_addr[n*ADDR_W +: ADDR_W]    = buf_out_addr;
        ep_buf_in_wren[n]                      = pass & buf_in_wren;
        ep_buf_in_commit[n]                    = pass & buf_in_commit;
        ep_buf_out_arm[n]                      = pass & buf_out_arm;
      end
    end
  end

  // Toggle and halt bookkeeping. Later assignments win: set beats clear beats
  // the EP0 auto-clear, and toggle_clr_all beats everything.
  always_comb begin
    tog_nxt  = toggles;
    halt_nxt = halts;
    for (int n = 0; n < NUM_EP; n++) begin
      if (pass && data_toggle_act && sel_q == 4'(n) && ep_mode(n) != MODE_ISO)
        tog_nxt[n] = ~toggles[n];
      if (halt_clr && !halt_set && halt_ep == 4'(n)) tog_nxt[n] = 1'b0;
      if (toggle_clr_all) tog_nxt[n] = 1'b0;
      if (n == 0 && ep0_setup) halt_nxt[n] = 1'b0;
      if (halt_clr && halt_ep == 4'(n)) halt_nxt[n] = 1'b0;
      if (halt_set && halt_ep == 4'(n)) halt_nxt[n] = 1'b1;
    end
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      toggles <= '0;
      halts   <= '0;
    end else begin
      toggles <= tog_nxt;
      halts   <= halt_nxt;
    end
  end

  // Registered return path. The capture is gated so a value taken while the
  // selection was settling can never surface for the new endpoint.
  logic             r_ready, r_cack, r_hasdata, r_aack;
  logic [7:0]       r_q;
  logic [LEN_W-1:0] r_len;

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_cack    <= 1'b0;
      r_q       <= '0;
      r_len     <= '0;
      r_hasdata <= 1'b0;
      r_aack    <= 1'b0;
    end else begin
      r_ready   <= ret_en & sel_ready;
      r_cack    <= ret_en & sel_cack;
      r_q       <= ret_en ? sel_rq : '0;
      r_len     <= ret_en ? sel_len : '0;
      r_hasdata <= ret_en & sel_hasdata;
      r_aack    <= ret_en & sel_aack;
    end
  end

  assign buf_in_ready      = ret_en & r_ready;
  assign buf_in_commit_ack = ret_en & r_cack;
  assign buf_out_q         = ret_en ? r_q : '0;
  assign buf_out_len       = ret_en ? r_len : '0;
  assign buf_out_hasdata   = ret_en & r_hasdata;
  assign buf_out_arm_ack   = ret_en & r_aack;

  assign endp_valid  = valid;
  assign endp_halted = valid & sel_halt;
  assign endp_mode   = valid ? sel_mode : 2'b00;
  assign data_toggle = (valid && sel_mode != MODE_ISO) ? {1'b0, sel_tog} : 2'b00;

endmodule

// File: tb/tb_usb2_endp_router.sv
// Testbench for usb2_endp_router: a directed table of cycles, hand-written
// multi-cycle sequences (EP0 auto-clear, reset mid-commit) and a randomized
// run checked against a behavioural model.
module tb_usb2_endp_router;

  localparam int         NUM_EP   = 4;
  localparam int         ADDR_W   = 9;
  localparam int         LEN_W    = 10;
  localparam logic [7:0] EP_MODES = 8'b01_10_10_00; // EP3 isoch, EP1/2 bulk
  localparam int         RW       = 4 + 8 + LEN_W;

  logic                     phy_clk = 1'b0;
  logic                     reset = 1'b1;
  logic [3:0]               sel_endp = '0;
  logic [ADDR_W-1:0]        buf_in_addr = '0;
  logic [7:0]               buf_in_data = '0;
  logic                     buf_in_wren = 1'b0, buf_in_commit = 1'b0;
  logic [LEN_W-1:0]         buf_in_commit_len = '0;
  logic                     buf_in_ready, buf_in_commit_ack;
  logic [ADDR_W-1:0]        buf_out_addr = '0;
  logic                     buf_out_arm = 1'b0;
  logic [7:0]               buf_out_q;
  logic [LEN_W-1:0]         buf_out_len;
  logic                     buf_out_hasdata, buf_out_arm_ack;
  logic                     data_toggle_act = 1'b0, toggle_clr_all = 1'b0;
  logic                     halt_set = 1'b0, halt_clr = 1'b0;
  logic [3:0]               halt_ep = '0;
  logic [NUM_EP*ADDR_W-1:0] ep_buf_in_addr, ep_buf_out_addr;
  logic [NUM_EP*8-1:0]      ep_buf_in_data;
  logic [NUM_EP-1:0]        ep_buf_in_wren, ep_buf_in_commit, ep_buf_out_arm;
  logic [NUM_EP*LEN_W-1:0]  ep_buf_in_commit_len;
  logic [NUM_EP-1:0]        ep_buf_in_ready = '0, ep_buf_in_commit_ack = '0;
  logic [NUM_EP*8-1:0]      ep_buf_out_q = '0;
  logic [NUM_EP*LEN_W-1:0]  ep_buf_out_len = '0;
  logic [NUM_EP-1:0]        ep_buf_out_hasdata = '0, ep_buf_out_arm_ack = '0;
  logic [1:0]               endp_mode, data_toggle, fsm_state;
  logic                     endp_valid, endp_halted;

  usb2_endp_router #(
    .NUM_EP(NUM_EP), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .EP_MODES(EP_MODES)
  ) dut (
    .phy_clk(phy_clk), .reset(reset), .sel_endp(sel_endp),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .buf_in_ready(buf_in_ready), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_out_addr(buf_out_addr), .buf_out_arm(buf_out_arm), .buf_out_q(buf_out_q),
    .buf_out_len(buf_out_len), .buf_out_hasdata(buf_out_hasdata),
    .buf_out_arm_ack(buf_out_arm_ack), .data_toggle_act(data_toggle_act),
    .toggle_clr_all(toggle_clr_all), .halt_set(halt_set), .halt_clr(halt_clr),
    .halt_ep(halt_ep), .ep_buf_in_addr(ep_buf_in_addr), .ep_buf_in_data(ep_buf_in_data),
    .ep_buf_in_wren(ep_buf_in_wren), .ep_buf_in_commit(ep_buf_in_commit),
    .ep_buf_in_commit_len(ep_buf_in_commit_len), .ep_buf_in_ready(ep_buf_in_ready),
    .ep_buf_in_commit_ack(ep_buf_in_commit_ack), .ep_buf_out_addr(ep_buf_out_addr),
    .ep_buf_out_arm(ep_buf_out_arm), .ep_buf_out_q(ep_buf_out_q),
    .ep_buf_out_len(ep_buf_out_len), .ep_buf_out_hasdata(ep_buf_out_hasdata),
    .ep_buf_out_arm_ack(ep_buf_out_arm_ack), .endp_mode(endp_mode),
    .data_toggle(data_toggle), .endp_valid(endp_valid), .endp_halted(endp_halted),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 phy_clk = ~phy_clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  localparam logic [6:0] WR = 7'b1000000, CM = 7'b0100000, ARM = 7'b0010000,
                         ACT = 7'b0001000, CLR = 7'b0000100, HS = 7'b0000010,
                         HC = 7'b0000001;

  task automatic drive(input logic [3:0] sel, input logic [6:0] ctl, input logic [3:0] hep);
    sel_endp        = sel;
    buf_in_addr     = 9'd5;
    buf_in_data     = 8'hA5;
    buf_in_wren     = ctl[6];
    buf_in_commit   = ctl[5];
    buf_out_arm     = ctl[4];
    data_toggle_act = ctl[3];
    toggle_clr_all  = ctl[2];
    halt_set        = ctl[1];
    halt_clr        = ctl[0];
    halt_ep         = hep;
  endtask

  task automatic bring_up(input logic [3:0] sel);
    drive(sel, 7'd0, 4'd0);
    reset = 1'b1;
    @(negedge phy_clk);
    reset = 1'b0;
    repeat (2) @(negedge phy_clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  ctl;
    logic [3:0]  hep;
    logic [3:0]  e_wren, e_arm;
    logic        e_valid;
    logic [1:0]  e_mode, e_tog;
    logic        e_halt, e_hd;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] sel, input logic [6:0] ctl, input logic [3:0] hep,
                              input logic [3:0] e_wren, input logic [3:0] e_arm,
                              input logic e_valid, input logic [1:0] e_mode,
                              input logic [1:0] e_tog, input logic e_halt, input logic e_hd,
                              input logic [31:0] e_data);
    vec_t v;
    v.sel = sel; v.ctl = ctl; v.hep = hep; v.e_wren = e_wren; v.e_arm = e_arm;
    v.e_valid = e_valid; v.e_mode = e_mode; v.e_tog = e_tog; v.e_halt = e_halt;
    v.e_hd = e_hd; v.e_data = e_data;
    return v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  int                 m_sel, m_guard;  // m_guard: guard cycles left before strobes pass
  bit                 m_tog[16], m_halt[16];
  logic [RW-1:0]      exp_q[$];        // expected registered return word per cycle

  function automatic int mode_of(input int n);
    if (n == 0) return 0;
    return int'((EP_MODES >> (2 * n)) & 8'd3);
  endfunction

  task automatic model_reset();
    m_sel = 0;
    m_guard = 2;
    for (int n = 0; n < 16; n++) begin
      m_tog[n] = 1'b0;
      m_halt[n] = 1'b0;
    end
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_check_step();
    bit valid, hlt, pass, ret_en;
    int md;
    logic [RW-1:0] rw, nw;
    valid  = (m_guard < 2) && (m_sel < NUM_EP);
    hlt    = valid ? m_halt[m_sel] : 1'b0;
    md     = valid ? mode_of(m_sel) : 0;
    pass   = (m_guard == 0) && (int'(sel_endp) == m_sel) && valid && !hlt;
    ret_en = (m_guard == 0) && valid && !hlt;

    chk("rnd_ep_wren", 64'(ep_buf_in_wren), (pass && buf_in_wren) ? 64'd1 << m_sel : 64'd0);
    chk("rnd_ep_commit", 64'(ep_buf_in_commit), (pass && buf_in_commit) ? 64'd1 << m_sel : 64'd0);
    chk("rnd_ep_arm", 64'(ep_buf_out_arm), (pass && buf_out_arm) ? 64'd1 << m_sel : 64'd0);
    chk("rnd_ep_in_addr", 64'(ep_buf_in_addr), valid ? 64'(buf_in_addr) << (ADDR_W * m_sel) : 64'd0);
    chk("rnd_ep_in_data", 64'(ep_buf_in_data), valid ? 64'(buf_in_data) << (8 * m_sel) : 64'd0);
    chk("rnd_ep_len", 64'(ep_buf_in_commit_len),
        valid ? 64'(buf_in_commit_len) << (LEN_W * m_sel) : 64'd0);
    chk("rnd_ep_out_addr", 64'(ep_buf_out_addr), valid ? 64'(buf_out_addr) << (ADDR_W * m_sel) : 64'd0);
    chk("rnd_valid", 64'(endp_valid), 64'(valid));
    chk("rnd_halted", 64'(endp_halted), 64'(hlt));
    chk("rnd_mode", 64'(endp_mode), 64'(md));
    chk("rnd_toggle", 64'(data_toggle), (valid && md != 1) ? 64'(m_tog[m_sel]) : 64'd0);
    rw = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("rnd_return", 64'({buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len,
                           buf_out_hasdata, buf_out_arm_ack}), ret_en ? 64'(rw) : 64'd0);

    // state after the coming edge
    nw = '0;
    if (ret_en)
      nw = {ep_buf_in_ready[m_sel], ep_buf_in_commit_ack[m_sel], ep_buf_out_q[8*m_sel +: 8],
            ep_buf_out_len[LEN_W*m_sel +: LEN_W], ep_buf_out_hasdata[m_sel],
            ep_buf_out_arm_ack[m_sel]};
    exp_q.push_back(nw);
    for (int n = 0; n < NUM_EP; n++) begin
      bit hit;
      hit = (int'(halt_ep) == n);
      if (toggle_clr_all) m_tog[n] = 1'b0;
      else if (halt_clr && hit && !halt_set) m_tog[n] = 1'b0;
      else if (pass && data_toggle_act && n == m_sel && mode_of(n) != 1) m_tog[n] = !m_tog[n];
      if (halt_set && hit) m_halt[n] = 1'b1;
      else if (halt_clr && hit) m_halt[n] = 1'b0;
      else if (n == 0 && m_sel == 0 && m_guard == 0 && sel_endp == 4'd0 && buf_in_commit)
        m_halt[n] = 1'b0;
    end
    if (m_guard == 2) m_guard = 1;
    else if (m_guard == 1) begin
      m_sel = int'(sel_endp);
      m_guard = 0;
    end else if (int'(sel_endp) != m_sel) m_guard = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // directed cycles after reset release, sel=0, EP3 isoch
    tbl.push_back(mk(0, WR, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, WR, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 32'h000000A5));
    tbl.push_back(mk(0, WR, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 32'h000000A5));
    tbl.push_back(mk(0, 0,  0, 4'b0000, 0, 1, 0, 0, 0, 1, 32'h000000A5));
    tbl.push_back(mk(1, WR, 0, 4'b0000, 0, 1, 0, 0, 0, 1, 32'h000000A5));
    tbl.push_back(mk(1, WR, 0, 4'b0000, 0, 1, 0, 0, 0, 0, 32'h000000A5));
    tbl.push_back(mk(1, WR|ACT, 0, 4'b0010, 0, 1, 2, 0, 0, 0, 32'h0000A500));
    tbl.push_back(mk(1, ACT, 0, 0, 0, 1, 2, 1, 0, 1, 32'h0000A500));
    tbl.push_back(mk(1, ACT, 0, 0, 0, 1, 2, 0, 0, 1, 32'h0000A500));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 2, 1, 0, 1, 32'h0000A500));
    tbl.push_back(mk(1, ACT|CLR, 0, 0, 0, 1, 2, 1, 0, 1, 32'h0000A500));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 2, 0, 0, 1, 32'h0000A500));
    tbl.push_back(mk(2, WR,  0, 0, 0, 1, 2, 0, 0, 1, 32'h0000A500));
    tbl.push_back(mk(2, WR,  0, 0, 0, 1, 2, 0, 0, 0, 32'h0000A500));
    tbl.push_back(mk(2, WR,  0, 4'b0100, 0, 1, 2, 0, 0, 0, 32'h00A50000));
    tbl.push_back(mk(2, ACT, 0, 0, 0, 1, 2, 0, 0, 1, 32'h00A50000));
    tbl.push_back(mk(2, HS|HC|ARM, 2, 0, 4'b0100, 1, 2, 1, 0, 1, 32'h00A50000));
    tbl.push_back(mk(2, ARM, 0, 0, 0, 1, 2, 1, 1, 0, 32'h00A50000));
    tbl.push_back(mk(2, HC|ARM, 2, 0, 0, 1, 2, 1, 1, 0, 32'h00A50000));
    tbl.push_back(mk(2, ARM, 0, 0, 4'b0100, 1, 2, 0, 0, 0, 32'h00A50000));
    tbl.push_back(mk(2, 0,   0, 0, 0, 1, 2, 0, 0, 1, 32'h00A50000));
    tbl.push_back(mk(3, 0,   0, 0, 0, 1, 2, 0, 0, 1, 32'h00A50000));
    tbl.push_back(mk(3, 0,   0, 0, 0, 1, 2, 0, 0, 0, 32'h00A50000));
    tbl.push_back(mk(3, ACT, 0, 0, 0, 1, 1, 0, 0, 0, 32'hA5000000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(3, ACT, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA5000000));
    tbl.push_back(mk(3, 0,   0, 0, 0, 1, 1, 0, 0, 1, 32'hA5000000));
    tbl.push_back(mk(9, WR|CM|ARM, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA5000000));
    tbl.push_back(mk(9, WR|CM|ARM, 0, 0, 0, 1, 1, 0, 0, 0, 32'hA5000000));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(9, WR|CM|ARM, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));

    ep_buf_out_hasdata = '1;
    drive(0, 7'd0, 0);
    reset = 1'b1;
    repeat (2) @(negedge phy_clk);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sel, tbl[i].ctl, tbl[i].hep);
      #1;
      chk($sformatf("tbl%0d_wren", i), 64'(ep_buf_in_wren), 64'(tbl[i].e_wren));
      chk($sformatf("tbl%0d_arm", i), 64'(ep_buf_out_arm), 64'(tbl[i].e_arm));
      chk($sformatf("tbl%0d_valid", i), 64'(endp_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_mode", i), 64'(endp_mode), 64'(tbl[i].e_mode));
      chk($sformatf("tbl%0d_toggle", i), 64'(data_toggle), 64'(tbl[i].e_tog));
      chk($sformatf("tbl%0d_halted", i), 64'(endp_halted), 64'(tbl[i].e_halt));
      chk($sformatf("tbl%0d_hasdata", i), 64'(buf_out_hasdata), 64'(tbl[i].e_hd));
      chk($sformatf("tbl%0d_data", i), 64'(ep_buf_in_data), 64'(tbl[i].e_data));
      if (tbl[i].e_valid == 1'b0 && tbl[i].sel == 4'd9)
        chk($sformatf("tbl%0d_commit", i), 64'(ep_buf_in_commit), 64'd0);
      @(negedge phy_clk);
    end

    // EP0 halt is cleared by the next commit (SETUP) on EP0
    bring_up(0);
    halt_set = 1'b1;
    halt_ep = 4'd0;
    @(negedge phy_clk);
    halt_set = 1'b0;
    buf_in_commit = 1'b1;
    #1;
    chk("ep0_halted", 64'(endp_halted), 64'd1);
    chk("ep0_commit_blocked", 64'(ep_buf_in_commit), 64'd0);
    @(negedge phy_clk);
    #1;
    chk("ep0_halt_autoclr", 64'(endp_halted), 64'd0);
    chk("ep0_commit_pass", 64'(ep_buf_in_commit), 64'd1);
    @(negedge phy_clk);

    // reset in the middle of a commit on EP2
    bring_up(2);
    data_toggle_act = 1'b1;
    @(negedge phy_clk);
    data_toggle_act = 1'b0;
    halt_set = 1'b1;
    halt_ep = 4'd1;
    @(negedge phy_clk);
    halt_set = 1'b0;
    buf_in_wren = 1'b1;
    buf_in_commit = 1'b1;
    #1;
    chk("ep2_tog_before_rst", 64'(data_toggle), 64'd1);
    chk("ep2_commit_before_rst", 64'(ep_buf_in_commit), 64'b0100);
    reset = 1'b1;
    #1;
    chk("rst_commit", 64'(ep_buf_in_commit), 64'd0);
    chk("rst_wren", 64'(ep_buf_in_wren), 64'd0);
    chk("rst_data", 64'(ep_buf_in_data), 64'd0);
    chk("rst_toggle", 64'(data_toggle), 64'd0);
    chk("rst_valid", 64'(endp_valid), 64'd0);
    chk("rst_hasdata", 64'(buf_out_hasdata), 64'd0);
    @(negedge phy_clk);
    reset = 1'b0;
    #1;
    chk("guard1_commit", 64'(ep_buf_in_commit), 64'd0);
    @(negedge phy_clk);
    #1;
    chk("guard2_commit", 64'(ep_buf_in_commit), 64'd0);
    @(negedge phy_clk);
    #1;
    chk("post_guard_commit", 64'(ep_buf_in_commit), 64'b0100);
    chk("post_rst_toggle", 64'(data_toggle), 64'd0);
    buf_in_wren = 1'b0;
    buf_in_commit = 1'b0;
    sel_endp = 4'd1;
    repeat (2) @(negedge phy_clk);
    #1;
    chk("ep1_halt_cleared", 64'(endp_halted), 64'd0);
    chk("ep1_valid", 64'(endp_valid), 64'd1);
    @(negedge phy_clk);

    // randomized run against the model
    reset = 1'b1;
    model_reset();
    @(negedge phy_clk);
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      int pick;
      pick = int'($urandom_range(0, 19));
      if (pick == 0) sel_endp = 4'($urandom_range(0, 15));
      else if (pick < 3) sel_endp = 4'($urandom_range(0, 4));
      buf_in_addr          = ADDR_W'($urandom);
      buf_in_data          = 8'($urandom);
      buf_in_commit_len    = LEN_W'($urandom);
      buf_out_addr         = ADDR_W'($urandom);
      buf_in_wren          = 1'($urandom);
      buf_in_commit        = 1'($urandom);
      buf_out_arm          = 1'($urandom);
      data_toggle_act      = 1'($urandom);
      toggle_clr_all       = ($urandom_range(0, 15) == 0);
      halt_set             = ($urandom_range(0, 15) == 0);
      halt_clr             = ($urandom_range(0, 7) == 0);
      halt_ep              = 4'($urandom_range(0, 5));
      ep_buf_in_ready      = NUM_EP'($urandom);
      ep_buf_in_commit_ack = NUM_EP'($urandom);
      ep_buf_out_q         = 32'($urandom);
      ep_buf_out_len       = {20'($urandom), 20'($urandom)};
      ep_buf_out_hasdata   = NUM_EP'($urandom);
      ep_buf_out_arm_ack   = NUM_EP'($urandom);
      #1;
      model_check_step();
      @(negedge phy_clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
